// File: rtl/seg_scan.sv
// Four-digit 7-segment display back-end with a sequential binary-to-BCD converter.
// Latency: decimal load to done is WIDTH+1 edges; a hex load commits one edge after it is accepted.
// Backpressure: a load while busy is dropped without queueing; busy is the only handshake.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   val, load   binary value and 1-cycle convert request (sampled only while idle)
//   blank       forces all anodes and segments off; conversion is unaffected
//   dp          active-high decimal point per digit, dp[0] = rightmost digit
//   busy, done  conversion in flight / 1-cycle commit pulse
//   ovf         last committed decimal value exceeded 9999 and was shown as 9999
//   seg         {an[3:0], dp, g..a}, all active-low, registered
// Optional feature macro: HEX_MODE_EN adds a 'hex' input that shows val[15:0] as raw nibbles.
module seg_scan #(
  parameter int WIDTH    = 26,
  parameter int SCAN_DIV = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] val,
  input  logic             load,
`ifdef HEX_MODE_EN
  input  logic             hex,
`endif
  input  logic             blank,
  input  logic [3:0]       dp,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [11:0]      seg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t             state;
  logic [WIDTH-1:0]   shreg;
  logic [31:0]        bcd;
  logic [31:0]        bcd_adj;
  logic [CW-1:0]      cnt;
  logic [15:0]        dig;      // committed digits, dig[4k +: 4] is digit k
`ifdef HEX_MODE_EN
  logic               hex_cap;  // mode of the conversion in flight
  logic               disp_hex; // mode of the committed digits
`endif

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift so
  // that it carries into the next decimal place after doubling.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 8; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      bcd      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      dig      <= '0;
`ifdef HEX_MODE_EN
      hex_cap  <= 1'b0;
      disp_hex <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shreg <= val;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
`ifdef HEX_MODE_EN
            hex_cap <= hex;
            state   <= hex ? COMMIT : SHIFT;
`else
            state <= SHIFT;
`endif
          end
        end
        SHIFT: begin
          bcd   <= {bcd_adj[30:0], shreg[WIDTH-1]};
          shreg <= {shreg[WIDTH-2:0], 1'b0};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
`ifdef HEX_MODE_EN
          disp_hex <= hex_cap;
          if (hex_cap) begin
            // shreg was never shifted on the hex path, so it still holds val
            dig <= shreg[15:0];
            ovf <= 1'b0;
          end else
`endif
          if (bcd[31:16] != 16'd0) begin
            dig <= 16'h9999;
            ovf <= 1'b1;
          end else begin
            dig <= bcd[15:0];
            ovf <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Active-low g..a patterns; anything outside the supported set is dark.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0:    glyph = 7'h40;
      4'h1:    glyph = 7'h79;
      4'h2:    glyph = 7'h24;
      4'h3:    glyph = 7'h30;
      4'h4:    glyph = 7'h19;
      4'h5:    glyph = 7'h12;
      4'h6:    glyph = 7'h02;
      4'h7:    glyph = 7'h78;
      4'h8:    glyph = 7'h00;
      4'h9:    glyph = 7'h10;
`ifdef HEX_MODE_EN
      4'hA:    glyph = 7'h08;
      4'hB:    glyph = 7'h03;
      4'hC:    glyph = 7'h46;
      4'hD:    glyph = 7'h21;
      4'hE:    glyph = 7'h06;
      4'hF:    glyph = 7'h0E;
`endif
      default: glyph = 7'h7F;
    endcase
  endfunction

  // Leading-zero suppression: a digit goes dark when it and every digit to
  // its left are zero. Digit 0 always shows. Hex displays never suppress.
  logic       z3, z2, z1;
  logic [3:0] lz;
  assign z3 = (dig[15:12] == 4'd0);
  assign z2 = z3 && (dig[11:8] == 4'd0);
  assign z1 = z2 && (dig[7:4] == 4'd0);
`ifdef HEX_MODE_EN
  assign lz = disp_hex ? 4'b0000 : {z3, z2, z1, 1'b0};
`else
  assign lz = {z3, z2, z1, 1'b0};
`endif

  logic [SCAN_DIV-1:0] presc;
  logic [1:0]          idx;
  logic [3:0]          cur_dig;
  logic [6:0]          cur_glyph;

  assign cur_dig   = dig[{idx, 2'b00} +: 4];
  assign cur_glyph = lz[idx] ? 7'h7F : glyph(cur_dig);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= 2'd0;
      seg   <= 12'hFFF;
    end else begin
      presc <= presc + 1'b1;
      if (&presc) begin
        idx <= idx + 2'd1;
      end
      if (blank) begin
        seg <= 12'hFFF;
      end else begin
        seg <= {~(4'b0001 << idx), ~dp[idx], cur_glyph};
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: each load pushes a modelled result to a
// scoreboard; done pops it, and the scan is checked slot by slot against it.
module tb_seg_scan;

  localparam int WIDTH    = 26;
  localparam int SCAN_DIV = 2;
  localparam int DWELL    = 1 << SCAN_DIV;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] val;
  logic             load;
  logic             hex;
  logic             blank;
  logic [3:0]       dp;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [11:0]      seg;

  seg_scan #(.WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .val   (val),
    .load  (load),
`ifdef HEX_MODE_EN
    .hex   (hex),
`endif
    .blank (blank),
    .dp    (dp),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .seg   (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ovf;
    logic [15:0] dig;
    logic        hx;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        shown;
  logic [11:0] seg_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int v, input logic h);
    exp_t e;
    e.hx = h;
    if (h) begin
      e.dig = v[15:0];
      e.ovf = 1'b0;
    end else if (v > 9999) begin
      e.dig = 16'h9999;
      e.ovf = 1'b1;
    end else begin
      e.dig = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [6:0] tb_glyph(input logic [3:0] d);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[d];
  endfunction

  function automatic logic [11:0] exp_word(input int slot);
    logic       dark;
    logic [3:0] an;
    logic [6:0] g;
    dark = 1'b0;
    if (!shown.hx && slot > 0) begin
      dark = 1'b1;
      for (int k = slot; k < 4; k++) begin
        if (shown.dig[4*k +: 4] != 4'd0) dark = 1'b0;
      end
    end
    g  = dark ? 7'h7F : tb_glyph(shown.dig[4*slot +: 4]);
    an = ~(4'b0001 << slot);
    return {an, ~dp[slot], g};
  endfunction

  // Drive a load for one cycle; returns on the negedge just after the edge that sampled it.
  task automatic do_load(input int v, input logic h, input logic push);
    @(negedge clk);
    val  = WIDTH'(v);
    hex  = h;
    load = 1'b1;
    if (push) exp_q.push_back(model(v, h));
    @(negedge clk);
    load = 1'b0;
    hex  = 1'b0;
  endtask

  // Waits for done, checks latency and busy duration, then pops the scoreboard.
  task automatic wait_done(input string tag, input int exp_lat);
    int   k;
    int   busy_n;
    logic seen;
    exp_t e;
    k = 0; busy_n = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_n++;
        k++;
        @(negedge clk);
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_latency"}, k, exp_lat);
      chk({tag, "_busy_edges"}, busy_n, exp_lat);
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
        shown = e;
      end else begin
        chk({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd1);
      end
    end
  endtask

  // Checks one full scan: slot 3 first, then 0, 1, 2 at DWELL-cycle spacing.
  task automatic check_scan(input string tag);
    logic found;
    logic [11:0] w;
    int slots [4];
    slots = '{3, 0, 1, 2};
    for (int s = 0; s < 4; s++) seg_q.push_back(exp_word(slots[s]));
    found = 1'b0;
    for (int i = 0; i < 4 * DWELL + 4 && !found; i++) begin
      @(negedge clk);
      if (seg[11:8] == 4'b0111) found = 1'b1;
    end
    chk({tag, "_scan_sync"}, 32'(found), 32'd1);
    for (int s = 0; s < 4; s++) begin
      w = seg_q.pop_front();
      if (found) chk($sformatf("%s_slot%0d", tag, slots[s]), 32'(seg), 32'(w));
      repeat (DWELL) @(negedge clk);
    end
  endtask

  int extra;

  initial begin
    rst_n = 1'b0; val = '0; load = 1'b0; hex = 1'b0; blank = 1'b0; dp = 4'b0000;
    shown = model(0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_seg", 32'(seg), 32'hFFF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_scan", 32'(seg), 32'hEC0);

    do_load(1234, 1'b0, 1'b1);
    wait_done("v1234", 27);
    check_scan("v1234");

    do_load(7, 1'b0, 1'b1);
    wait_done("v7", 27);
    check_scan("v7");
    dp = 4'b0100;
    check_scan("v7_dp");
    chk("v7_dp_slot2_word", 32'(exp_word(2)), 32'hB7F);
    dp = 4'b0000;

    // Second load while busy must be dropped.
    do_load(10000, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    val = WIDTH'(5); load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_done("v10000", 23);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("v10000_single_done", extra, 0);
    chk("v10000_ovf_hold", 32'(ovf), 32'd1);
    check_scan("v10000");

    // Reset in the middle of SHIFT aborts the conversion.
    do_load(4321, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_seg", 32'(seg), 32'hFFF);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    exp_q.delete();
    shown = model(0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("abort_no_done", extra, 0);
    check_scan("abort_zero");

    do_load(42, 1'b0, 1'b1);
    wait_done("v42", 27);
    check_scan("v42");

    // A load in the same cycle as done is accepted.
    do_load(3, 1'b0, 1'b1);
    wait_done("v3", 27);
    val = WIDTH'(9876); load = 1'b1;
    exp_q.push_back(model(9876, 1'b0));
    @(negedge clk);
    load = 1'b0;
    wait_done("v9876_b2b", 27);
    check_scan("v9876");

    blank = 1'b1;
    @(negedge clk);
    chk("blank_seg", 32'(seg), 32'hFFF);
    blank = 1'b0;

`ifdef HEX_MODE_EN
    do_load(32'hBEEF, 1'b1, 1'b1);
    wait_done("hexbeef", 1);
    check_scan("hexbeef");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
